// File: rtl/dac_sample_pacer.sv
// Stereo sample FIFO and rate pacer feeding the SPI DAC driver. Signed 16-bit pairs are
// buffered, popped at a programmable rate, converted to 12-bit offset-binary with
// round-half-up and positive saturation, and presented with a stretched ready level.
module dac_sample_pacer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned READY_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [15:0]              in_l,
  input  logic [15:0]              in_r,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic [15:0]              rate_div,
  input  logic                     underrun_clr,
  output logic [11:0]              sample_in_1,
  output logic [11:0]              sample_in_2,
  output logic                     sample_ready,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(READY_HOLD + 1);

  logic [15:0]   mem_l_q [DEPTH];
  logic [15:0]   mem_r_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   pace_q, pace_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [11:0]   out1_q, out1_d;
  logic [11:0]   out2_q, out2_d;
  logic          underrun_q, underrun_d;
  logic          push, tick, pop;

  // Round half up at bit 3, saturate on positive overflow, flip MSB for offset-binary.
  function automatic logic [11:0] to_dac(input logic [15:0] x);
    logic [16:0] s;
    s = {x[15], x} + 17'd8;
    if (!s[16] && s[15]) begin
      return 12'hFFF;
    end
    return {~s[15], s[14:4]};
  endfunction

  // Handshake and pacer decode; in_ready deliberately ignores a same-cycle pop.
  always_comb begin
    in_ready = (level_q != (AW+1)'(DEPTH));
    push     = in_valid && in_ready;
    tick     = enable && (pace_q == 16'd0);
    pop      = tick && (level_q != '0);
  end

  // Next-state for pointers, level, pacer, hold counter, outputs and underrun flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pace_d     = pace_q;
    hold_d     = hold_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    underrun_d = underrun_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      out1_d   = to_dac(mem_l_q[rd_ptr_q]);
      out2_d   = to_dac(mem_r_q[rd_ptr_q]);
    end
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

    // Counter parks at zero while disabled so the first enabled cycle ticks.
    if (!enable) begin
      pace_d = 16'd0;
    end else if (pace_q == 16'd0) begin
      pace_d = rate_div;
    end else begin
      pace_d = pace_q - 16'd1;
    end

    if (pop) begin
      hold_d = HW'(READY_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end

    // A set from an empty tick takes priority over a clear in the same cycle.
    if (tick && !pop) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= in_l;
      mem_r_q[wr_ptr_q] <= in_r;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pace_q     <= 16'd0;
      hold_q     <= '0;
      out1_q     <= 12'h800;
      out2_q     <= 12'h800;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pace_q     <= pace_d;
      hold_q     <= hold_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_in_1  = out1_q;
  assign sample_in_2  = out2_q;
  assign sample_ready = (hold_q != '0);
  assign underrun     = underrun_q;
  assign level        = level_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Bench for dac_sample_pacer: a queue-based reference model tracks absolute tick times and
// ready-expiry cycles; scenario tasks mix directed constant checks with per-cycle model checks.
module tb_dac_sample_pacer;

  localparam int DEPTH = 8;
  localparam int HOLD  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 27 + LW;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [15:0]   in_l = '0, in_r = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          enable = 1'b0;
  logic [15:0]   rate_div = '0;
  logic          underrun_clr = 1'b0;
  logic [11:0]   sample_in_1, sample_in_2;
  logic          sample_ready, underrun;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  dac_sample_pacer #(.DEPTH(DEPTH), .READY_HOLD(HOLD)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .in_l         (in_l),
    .in_r         (in_r),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .rate_div     (rate_div),
    .underrun_clr (underrun_clr),
    .sample_in_1  (sample_in_1),
    .sample_in_2  (sample_in_2),
    .sample_ready (sample_ready),
    .underrun     (underrun),
    .level        (level)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  int          m_cyc = 0, m_next = 0, m_rdy_until = 0;
  logic [11:0] m_o1 = 12'h800, m_o2 = 12'h800;
  logic        m_und = 1'b0;
  logic        m_push, m_tick, m_pop;
  logic [31:0] m_pair;

  function automatic logic [11:0] conv(input logic [15:0] x);
    int v;
    v = $signed(x) + 8;
    if (v > 32767) return 12'hFFF;
    return 12'((v >>> 4) + 2048);
  endfunction

  // m_cyc counts edges since reset; ticks are scheduled as absolute edge numbers.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mq.delete();
      m_o1 = 12'h800; m_o2 = 12'h800; m_und = 1'b0;
      m_cyc = 0; m_next = 0; m_rdy_until = 0;
    end else begin
      m_cyc++;
      m_push = in_valid && (mq.size() != DEPTH);
      m_tick = enable && (m_cyc >= m_next);
      m_pop  = m_tick && (mq.size() != 0);
      if (m_pop) begin
        m_pair = mq.pop_front();
        m_o1 = conv(m_pair[31:16]);
        m_o2 = conv(m_pair[15:0]);
        m_rdy_until = m_cyc + HOLD;
      end
      if (m_tick && !m_pop) m_und = 1'b1;
      else if (underrun_clr) m_und = 1'b0;
      if (m_push) mq.push_back({in_l, in_r});
      if (!enable) m_next = m_cyc + 1;
      else if (m_tick) m_next = m_cyc + int'(rate_div) + 1;
    end
  end

  function automatic logic [VW-1:0] mdl_vec();
    return {mq.size() != DEPTH, m_o1, m_o2, m_cyc < m_rdy_until, m_und, LW'(mq.size())};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {in_ready, sample_in_1, sample_in_2, sample_ready, underrun, level};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0; in_valid = 1'b0; enable = 1'b0; rate_div = '0; underrun_clr = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({sample_in_1, sample_in_2} !== 24'h800800) begin
      n_fail++; $display("FAIL reset_out got %h/%h want 800/800", sample_in_1, sample_in_2);
    end
    n_tests++;
    if ({sample_ready, underrun, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_flags got rdy=%b und=%b inr=%b want 0 0 1",
                         sample_ready, underrun, in_ready);
    end
    n_tests++;
    if (level !== '0) begin
      n_fail++; $display("FAIL reset_level got %0d want 0", level);
    end
    rstb = 1'b1;
  endtask

  task automatic test_conversion();
    logic [31:0] pairs [3] = '{32'h0000FFF8, 32'h7FF88000, 32'hFFF71234};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      {in_l, in_r} = pairs[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; rate_div = 16'd3; enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL conv_cycle%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i == 0) begin
        n_tests++;
        if ({sample_in_1, sample_in_2, sample_ready} !== {12'h800, 12'h800, 1'b1}) begin
          n_fail++; $display("FAIL conv_first got %h/%h rdy=%b want 800/800 1",
                             sample_in_1, sample_in_2, sample_ready);
        end
      end
      if (i == 4) begin
        n_tests++;
        if ({sample_in_1, sample_in_2} !== {12'hFFF, 12'h000}) begin
          n_fail++; $display("FAIL conv_second got %h/%h want fff/000", sample_in_1, sample_in_2);
        end
      end
    end
    n_tests++;
    if ({sample_in_1, sample_in_2, sample_ready} !== {12'h7FF, 12'h923, 1'b0}) begin
      n_fail++; $display("FAIL conv_last got %h/%h rdy=%b want 7ff/923 0",
                         sample_in_1, sample_in_2, sample_ready);
    end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_l = 16'($urandom); in_r = 16'($urandom);
      @(negedge clk);
    end
    n_tests++;
    if ({level, in_ready} !== {LW'(DEPTH), 1'b0}) begin
      n_fail++; $display("FAIL full_level got lvl=%0d inr=%b want %0d 0", level, in_ready, DEPTH);
    end
    in_valid = 1'b0; rate_div = 16'd0; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL full_drain%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    enable = 1'b1; rate_div = 16'd9;
    @(negedge clk);
    n_tests++;
    if ({underrun, sample_in_1, sample_in_2} !== {1'b1, 12'h800, 12'h800}) begin
      n_fail++; $display("FAIL und_set got und=%b %h/%h want 1 800/800",
                         underrun, sample_in_1, sample_in_2);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++; $display("FAIL und_clr got %b want 0", underrun);
    end
    underrun_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL und_wait%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if (underrun !== 1'b1) begin
      n_fail++; $display("FAIL und_set_wins got %b want 1", underrun);
    end
    underrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_l = 16'($urandom); in_r = 16'($urandom);
      @(negedge clk);
    end
    rate_div = 16'd0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_l = 16'($urandom); in_r = 16'($urandom);
      @(negedge clk);
      n_tests++;
      if (level !== LW'(3) || dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL simul%0d got lvl=%0d %h want lvl=3 %h",
                           i, level, dut_vec(), mdl_vec());
      end
    end
    rate_div = 16'd1;
    for (int i = 0; i < 50; i++) begin
      in_valid = (i < 40) && (i % 2 == 0);
      in_l = 16'($urandom); in_r = 16'($urandom);
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL stream%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 2) != 0);
      in_l         = 16'($urandom);
      in_r         = 16'($urandom);
      enable       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) rate_div = 16'($urandom_range(0, 5));
      underrun_clr = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random%0d got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    in_valid = 1'b0; enable = 1'b0; underrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_l = 16'($urandom); in_r = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; rate_div = 16'd20; enable = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({level, sample_ready} !== {LW'(5), 1'b1}) begin
      n_fail++; $display("FAIL mid_pre got lvl=%0d rdy=%b want 5 1", level, sample_ready);
    end
    #2 rstb = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== {1'b1, 12'h800, 12'h800, 1'b0, 1'b0, LW'(0)}) begin
      n_fail++; $display("FAIL mid_async got %h want %h", dut_vec(),
                         {1'b1, 12'h800, 12'h800, 1'b0, 1'b0, LW'(0)});
    end
    enable = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_full();
    test_underrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
Stereo sample buffer and rate pacer that sits directly upstream of the SPI DAC driver. It accepts signed 16-bit left/right samples from the SID mixer through a valid/ready handshake and buffers them in a small FIFO. At a programmable sample rate it pops one stereo pair, converts it to 12-bit offset-binary with rounding and saturation, and presents it on sample_in_1/sample_in_2 together with a stretched sample_ready level the DAC driver can sample.

Parameters:
DEPTH, 8, FIFO depth in stereo pairs; power of two, 2..64.
READY_HOLD, 8, clocks sample_ready stays high after each update; must be >=4, the DAC driver's internal clock-divide period.

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
in_l  input  16  left sample, signed two's complement
in_r  input  16  right sample, signed two's complement
in_valid  input  1  in_l/in_r valid this cycle
in_ready  output  1  FIFO can accept a pair; combinational, equals (level != DEPTH)
enable  input  1  pacer run enable
rate_div  input  16  clocks per output sample minus 1
underrun_clr  input  1  clears the underrun flag
sample_in_1  output  12  left DAC code, unsigned offset-binary
sample_in_2  output  12  right DAC code, unsigned offset-binary
sample_ready  output  1  new pair presented; held high for READY_HOLD clocks
underrun  output  1  sticky: a pacer tick found the FIFO empty
level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rstb low, asynchronous): FIFO empty (level=0), sample_in_1=sample_in_2=12'h800 (midscale), sample_ready=0, underrun=0, pacer counter=0, hold counter=0. in_ready reads 1.
- Push: a push occurs on a rising clk when in_valid && in_ready. The pair is written at the write pointer, and the pointer wraps modulo DEPTH. in_ready ignores any pop in the same cycle, so a full FIFO never accepts a push, even while popping.
- Pacer, enable=1: a down-counter ticks in the cycle where it equals 0, then reloads rate_div; otherwise it decrements. rate_div=0 gives a tick every cycle. The tick period is rate_div+1 clocks.
- A rate_div change takes effect at the next reload.
- Pacer, enable=0: the counter is forced to 0 and no ticks occur. Outputs, FIFO and underrun are held. The hold counter keeps decrementing, so sample_ready self-terminates.
- The first tick comes in the first cycle with enable=1.
- Tick with level>0:
  - Pop the head pair and register its converted values onto sample_in_1/2 at the same clock edge.
  - Load the hold counter with READY_HOLD.
- Tick with level=0:
  - Set underrun; outputs keep their last values; the hold counter is not reloaded.
  - A push in the same cycle still completes, and that pair is popped on the next tick.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- sample_ready = (hold counter != 0). The hold counter decrements to 0 and saturates there. A new update reloads it, so back-to-back updates keep sample_ready continuously high.
- Conversion, per channel:
  - s = in + 8, computed 17-bit signed (round half up at bit 3).
  - If s > 32767, out = 12'hFFF.
  - Else out = {~s[15], s[14:4]}.
  - Negative overflow cannot occur.
- Latency:
  - A pair pushed into an empty FIFO at edge N is eligible for the first tick in cycle N+1 or later.
  - Its outputs are visible after that tick's edge.
  - sample_ready rises on the same edge as the data.
- underrun_clr: clears underrun at the next edge. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation: all state is returned to reset values immediately, and buffered samples are discarded.

Test Plan:
- Reset then idle: rstb pulse low → sample_in_1/2=12'h800, sample_ready=0, underrun=0, level=0, in_ready=1.
- Conversion: push pairs (0x0000,0xFFF8), (0x7FF8,0x8000), (0xFFF7,0x1234), rate_div=3, enable=1 → outputs (0x800,0x800), (0xFFF,0x000), (0x7FF,0x923). Updates spaced exactly 4 clocks; sample_ready high from each update onward. Since READY_HOLD=8 > 4, it stays continuously high through all three updates and drops 8 clocks after the last update.
- Full/backpressure, DEPTH=8, enable=0: push 8 pairs → level=8, in_ready=0; the 9th in_valid is not accepted. Enable with rate_div=0 → in_ready=1 on the cycle after the first pop; data emerges in push order.
- Underrun: FIFO empty, enable=1, rate_div=9 → underrun=1 at the first tick and outputs unchanged. Assert underrun_clr in a non-tick cycle → underrun=0 next edge. Assert it coincident with an empty tick → underrun remains 1.
- Simultaneous push/pop at level=3 on a tick cycle → level stays 3. Pointer wrap is exercised by streaming 20 pairs at rate_div=1 and checking order.
- Reset mid-stream: level=5 and sample_ready=1, drop rstb asynchronously between edges → all outputs return to reset values without waiting for clk.
